// File: rtl/add_sub_if.sv
// add_sub_if: valid/ready operand and result bundle for add_sub_pipe (ovf present with ADD_SUB_OVF_EN)
interface add_sub_if #(
  parameter int N = 16,
  parameter int TAG_W = 4
);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic s;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [N:0] Y;
  logic [TAG_W-1:0] out_tag;
`ifdef ADD_SUB_OVF_EN
  logic ovf;
  modport master (output in_valid, A, B, s, in_tag, out_ready, input in_ready, out_valid, Y, out_tag, ovf);
  modport slave (input in_valid, A, B, s, in_tag, out_ready, output in_ready, out_valid, Y, out_tag, ovf);
`else
  modport master (output in_valid, A, B, s, in_tag, out_ready, input in_ready, out_valid, Y, out_tag);
  modport slave (input in_valid, A, B, s, in_tag, out_ready, output in_ready, out_valid, Y, out_tag);
`endif
endinterface

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined exact signed add/subtract with segmented carry chain; ADD_SUB_OVF_EN adds ovf
module add_sub_pipe #(
  parameter int N = 16,
  parameter int STAGES = 4,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  add_sub_if.slave bus
);
  localparam int W = N + 1;
  localparam int SEG = (W + STAGES - 1) / STAGES;
  localparam int WP = SEG * STAGES;
  // Operands are sign-extended to a whole number of segments; bits above N are discarded at the output.
  logic [WP-1:0] xa [STAGES];
  logic [WP-1:0] xb [STAGES];
  logic [WP-1:0] sm [STAGES];
  logic c [STAGES];
  logic v [STAGES];
  logic [TAG_W-1:0] tg [STAGES];
  logic [WP-1:0] pa [STAGES];
  logic [WP-1:0] pb [STAGES];
  logic [WP-1:0] ps [STAGES];
  logic pc [STAGES];
  logic pv [STAGES];
  logic [TAG_W-1:0] pt [STAGES];
  logic [SEG:0] segs [STAGES];
  logic adv;
  assign adv = ~v[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;
  assign pa[0] = {{(WP-N){bus.A[N-1]}}, bus.A};
  assign pb[0] = {{(WP-N){bus.B[N-1]}}, bus.B} ^ {WP{bus.s}};
  assign ps[0] = '0;
  assign pc[0] = bus.s;
  assign pv[0] = bus.in_valid;
  assign pt[0] = bus.in_tag;
  for (genvar i = 1; i < STAGES; i++) begin : g_link
    assign pa[i] = xa[i-1];
    assign pb[i] = xb[i-1];
    assign ps[i] = sm[i-1];
    assign pc[i] = c[i-1];
    assign pv[i] = v[i-1];
    assign pt[i] = tg[i-1];
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_seg
    assign segs[i] = {1'b0, pa[i][i*SEG +: SEG]} + {1'b0, pb[i][i*SEG +: SEG]} + {{SEG{1'b0}}, pc[i]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        xa[k] <= '0;
        xb[k] <= '0;
        sm[k] <= '0;
        c[k] <= 1'b0;
        v[k] <= 1'b0;
        tg[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        xa[k] <= pa[k];
        xb[k] <= pb[k];
        sm[k] <= ps[k];
        sm[k][k*SEG +: SEG] <= segs[k][SEG-1:0];
        c[k] <= segs[k][SEG];
        v[k] <= pv[k];
        tg[k] <= pt[k];
      end
    end
  end
  assign bus.out_valid = v[STAGES-1];
  assign bus.Y = sm[STAGES-1][N:0];
  assign bus.out_tag = tg[STAGES-1];
`ifdef ADD_SUB_OVF_EN
  assign bus.ovf = bus.Y[N] ^ bus.Y[N-1];
`endif
endmodule
